dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Load/store access controller between the MEM pipeline stage and `data_ram`. It takes one byte, halfword or word request from MEM, checks alignment and drives `data_ram`'s ce/we/addr/sel/data through a programmable number of wait states. It returns sign- or zero-extended load data and holds the pipeline with `stallreq_o` until the access completes. Byte order is big-endian: addr[1:0]=00 selects bits [31:24].

## Interface
- `WAIT_STATES`, default 1: extra access cycles beyond the first; legal range 0..15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_i`  in  1  MEM stage has a memory instruction this cycle.
- `op_i`  in  3  operation: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
- `addr_i`  in  32  effective byte address.
- `wdata_i`  in  32  store data, right-justified.
- `flush_i`  in  1  pipeline flush from ctrl.
- `mem_ce_o`  out  1  `data_ram` chip enable.
- `mem_we_o`  out  1  `data_ram` write enable.
- `mem_addr_o`  out  32  `data_ram` address, word-aligned: addr_i with [1:0] forced to 00.
- `mem_sel_o`  out  4  `data_ram` byte lanes.
- `mem_data_o`  out  32  `data_ram` write data.
- `mem_data_i`  in  32  `data_ram` read data; combinational from address.
- `rdata_o`  out  32  extended load result.
- `done_o`  out  1  one-cycle completion pulse.
- `exc_o`  out  1  one-cycle address-error pulse.
- `badaddr_o`  out  32  faulting address; valid while exc_o=1.
- `stallreq_o`  out  1  stall request to ctrl.

## Operation
- States: IDLE, ACCESS, DONE, ERR. Reset enters IDLE.
- Reset values: every output is 0 and the wait counter is 0.
- Alignment check:
  - LH, LHU and SH fault when addr_i[0]=1.
  - LW and SW fault when addr_i[1:0]≠00.
  - Byte operations never fault.
- IDLE:
  - With req_i=1, op_i, addr_i and wdata_i are captured.
  - Aligned request: go to ACCESS and load the counter with WAIT_STATES.
  - Misaligned request: go to ERR and latch addr_i into badaddr_o.
  - With req_i=0, stay in IDLE.
- Sel generation (big-endian), with a = addr[1:0]:
  - Byte: sel = 1000 >> a.
  - Halfword: sel = 1100 when a=00, 0011 when a=10.
  - Word: sel = 1111.
- Store data replication:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- ACCESS:
  - mem_ce_o=1; mem_we_o=1 for stores and 0 for loads.
  - mem_addr_o, mem_sel_o and mem_data_o come from the captured request and stay constant for the whole state.
  - Counter>0: decrement and stay in ACCESS.
  - Counter=0: go to DONE. For a load, also register the extracted, extended `mem_data_i` into rdata_o on this edge.
- Load extraction:
  - Bytes are taken from lane 3−a.
  - Halfwords come from [31:16] when a=00 and from [15:0] when a=10.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- DONE: done_o=1 for one cycle, then unconditionally IDLE. req_i is not sampled in DONE.
- ERR: exc_o=1 for one cycle, no RAM access, then IDLE.
- rdata_o holds its value until the next load completes. Stores leave it unchanged.
- flush_i=1 forces IDLE on the next edge from any state, and takes priority over all other transitions.
  - No done_o or exc_o follows a flush.
  - A store flushed in ACCESS has already written RAM at least once; this is accepted behaviour.
- Repeated writes of the same store during wait states are harmless and allowed.

## Timing
- Outputs other than stallreq_o are registered or decoded from state.
- stallreq_o is combinational:
  - 1 in IDLE when req_i=1 and flush_i=0.
  - 1 throughout ACCESS.
  - 0 in DONE, ERR and idle cycles.
- Latency from request accept (IDLE edge) to done_o: WAIT_STATES+2 cycles.
  - ACCESS lasts WAIT_STATES+1 cycles.
  - DONE lasts one cycle.
- Back-to-back requests: the next request can be accepted in the IDLE cycle immediately after DONE. Minimum period is WAIT_STATES+3 cycles per access.
- An error costs two cycles: the IDLE accept cycle, then ERR.
- mem_ce_o is 0 outside ACCESS. mem_we_o is never 1 while mem_ce_o is 0.
- Reset asserted mid-ACCESS: outputs go to 0 immediately (asynchronous), with no done_o or exc_o. The RAM write is abandoned if no edge has occurred yet.

## Test plan
- SW, WAIT_STATES=1, addr 0x100, wdata 0xDEADBEEF -> mem_sel_o=1111 and mem_we_o=1 for 2 cycles; done_o on cycle 3; stallreq_o is 1 for the first 3 cycles (IDLE + 2 ACCESS) and 0 in the DONE cycle; a following LW 0x100 returns rdata_o=0xDEADBEEF.
- SB 0x55 at addr 0x101 -> mem_sel_o=0100, mem_data_o=0x55555555; then LB 0x101 -> rdata_o=0x00000055; SB 0xA5 at 0x102 then LB 0x102 -> 0xFFFFFFA5, LBU 0x102 -> 0x000000A5.
- SH 0x8001 at 0x202, then LH 0x202 -> 0xFFFF8001, LHU 0x202 -> 0x00008001, sel=0011.
- LW at 0x203 -> exc_o pulses one cycle after accept, badaddr_o=0x00000203, mem_ce_o stays 0, no done_o.
- WAIT_STATES=0 and WAIT_STATES=15 builds: LW latency 2 and 17 cycles respectively; back-to-back requests are each accepted the cycle after DONE.
- flush_i during ACCESS of an LW -> IDLE next cycle, no done_o, rdata_o unchanged. rst mid-ACCESS -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge: load/store access controller between the MEM stage and data_ram.
// Checks alignment, drives data_ram through WAIT_STATES extra cycles, returns
// big-endian extracted and extended load data, and stalls the pipeline.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for req_i; request captured here
// ACCESS | data_ram enabled for WAIT_STATES+1 cycles
// DONE   | one-cycle done_o pulse, load data already in rdata_o
// ERR    | one-cycle exc_o pulse for a misaligned request

module dmem_bridge #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        exc_o,
    output logic [31:0] badaddr_o,
    output logic        stallreq_o
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] badaddr_q, badaddr_d;

    logic        misalign;
    logic        is_store;
    logic [1:0]  lane_a;
    logic [3:0]  sel;
    logic [31:0] wrep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Alignment check on the incoming request.
    always_comb begin
        misalign = 1'b0;
        case (op_i)
            OP_LH, OP_LHU, OP_SH: misalign = addr_i[0];
            OP_LW, OP_SW:         misalign = |addr_i[1:0];
            default:              misalign = 1'b0;
        endcase
    end

    assign is_store = op_q[2] & (op_q[1] | op_q[0]);
    assign lane_a   = addr_q[1:0];

    // Byte-lane select and store-data replication from the captured request.
    always_comb begin
        sel  = 4'b1111;
        wrep = wdata_q;
        case (op_q)
            OP_LB, OP_LBU, OP_SB: begin
                sel  = 4'b1000 >> lane_a;
                wrep = {4{wdata_q[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                sel  = lane_a[1] ? 4'b0011 : 4'b1100;
                wrep = {2{wdata_q[15:0]}};
            end
            default: begin
                sel  = 4'b1111;
                wrep = wdata_q;
            end
        endcase
    end

    // Big-endian extraction and sign/zero extension of the RAM read data.
    always_comb begin
        ld_byte = 8'h00;
        case (lane_a)
            2'b00:   ld_byte = mem_data_i[31:24];
            2'b01:   ld_byte = mem_data_i[23:16];
            2'b10:   ld_byte = mem_data_i[15:8];
            default: ld_byte = mem_data_i[7:0];
        endcase
        ld_half = lane_a[1] ? mem_data_i[15:0] : mem_data_i[31:16];
        ld_ext  = mem_data_i;
        case (op_q)
            OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_ext = {24'h000000, ld_byte};
            OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_ext = {16'h0000, ld_half};
            default: ld_ext = mem_data_i;
        endcase
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        badaddr_d = badaddr_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        op_d    = op_i;
                        addr_d  = addr_i;
                        wdata_d = wdata_i;
                        if (misalign) begin
                            state_d   = ST_ERR;
                            badaddr_d = addr_i;
                        end else begin
                            state_d = ST_ACCESS;
                            cnt_d   = WS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = ST_DONE;
                        if (!is_store) begin
                            rdata_d = ld_ext;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= 3'b000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            cnt_q     <= 4'd0;
            rdata_q   <= 32'h0;
            badaddr_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            badaddr_q <= badaddr_d;
        end
    end

    // RAM-side outputs are gated by ACCESS so they read zero in every other state.
    assign mem_ce_o   = (state_q == ST_ACCESS);
    assign mem_we_o   = mem_ce_o & is_store;
    assign mem_addr_o = mem_ce_o ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_sel_o  = mem_ce_o ? sel : 4'b0000;
    assign mem_data_o = mem_ce_o ? wrep : 32'h0;

    assign rdata_o    = rdata_q;
    assign badaddr_o  = badaddr_q;
    assign done_o     = (state_q == ST_DONE);
    assign exc_o      = (state_q == ST_ERR);
    assign stallreq_o = ((state_q == ST_IDLE) & req_i & ~flush_i) | (state_q == ST_ACCESS);

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: a WAIT_STATES=1 instance backed by a small
// RAM model, plus WAIT_STATES=0 and 15 instances for latency checks.
module tb_dmem_bridge;

    logic        clk;
    logic        rst;
    logic        req, req0, req15;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic        flush;

    logic        ce, we, done, exc, stall;
    logic [31:0] maddr, mdata, mrdata, rdata, badaddr;
    logic [3:0]  sel;

    logic        ce0, we0, done0, exc0, stall0;
    logic [31:0] maddr0, mdata0, rdata0, badaddr0;
    logic [3:0]  sel0;
    logic        ce15, we15, done15, exc15, stall15;
    logic [31:0] maddr15, mdata15, rdata15, badaddr15;
    logic [3:0]  sel15;

    logic [31:0] ram [0:255];

    int checks   = 0;
    int failures = 0;

    dmem_bridge #(.WAIT_STATES(1)) u_dut (
        .clk(clk), .rst(rst), .req_i(req), .op_i(op), .addr_i(addr), .wdata_i(wdata),
        .flush_i(flush), .mem_ce_o(ce), .mem_we_o(we), .mem_addr_o(maddr),
        .mem_sel_o(sel), .mem_data_o(mdata), .mem_data_i(mrdata), .rdata_o(rdata),
        .done_o(done), .exc_o(exc), .badaddr_o(badaddr), .stallreq_o(stall)
    );

    dmem_bridge #(.WAIT_STATES(0)) u_w0 (
        .clk(clk), .rst(rst), .req_i(req0), .op_i(op), .addr_i(addr), .wdata_i(wdata),
        .flush_i(1'b0), .mem_ce_o(ce0), .mem_we_o(we0), .mem_addr_o(maddr0),
        .mem_sel_o(sel0), .mem_data_o(mdata0), .mem_data_i(32'h12345678), .rdata_o(rdata0),
        .done_o(done0), .exc_o(exc0), .badaddr_o(badaddr0), .stallreq_o(stall0)
    );

    dmem_bridge #(.WAIT_STATES(15)) u_w15 (
        .clk(clk), .rst(rst), .req_i(req15), .op_i(op), .addr_i(addr), .wdata_i(wdata),
        .flush_i(1'b0), .mem_ce_o(ce15), .mem_we_o(we15), .mem_addr_o(maddr15),
        .mem_sel_o(sel15), .mem_data_o(mdata15), .mem_data_i(32'hCAFEF00D), .rdata_o(rdata15),
        .done_o(done15), .exc_o(exc15), .badaddr_o(badaddr15), .stallreq_o(stall15)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte-lane RAM model; sel bit i covers data bits [8i+7:8i].
    assign mrdata = ram[maddr[9:2]];
    always @(posedge clk) begin
        if (ce && we) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) ram[maddr[9:2]][8*i +: 8] <= mdata[8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Full aligned access on the WAIT_STATES=1 instance.
    task automatic do_access(input string tag, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] esel,
                             input logic [31:0] edata, input logic st,
                             input logic [31:0] erdata);
        op = o; addr = a; wdata = wd; req = 1'b1;
        #1;
        chk({tag, "_idle_stall"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1 req = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            chk({tag, "_acc_ce"}, 32'(ce), 32'd1);
            chk({tag, "_acc_we"}, 32'(we), 32'(st));
            chk({tag, "_acc_sel"}, 32'(sel), 32'(esel));
            chk({tag, "_acc_addr"}, maddr, {a[31:2], 2'b00});
            if (st) chk({tag, "_acc_data"}, mdata, edata);
            chk({tag, "_acc_stall"}, 32'(stall), 32'd1);
            chk({tag, "_acc_done"}, 32'(done), 32'd0);
            step();
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_stall"}, 32'(stall), 32'd0);
        chk({tag, "_done_ce"}, 32'({ce, we}), 32'd0);
        chk({tag, "_rdata"}, rdata, erdata);
        step();
        chk({tag, "_post_done"}, 32'(done), 32'd0);
    endtask

    task automatic do_err(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] erdata);
        op = o; addr = a; wdata = 32'h0; req = 1'b1;
        #1;
        chk({tag, "_idle_stall"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1 req = 1'b0;
        #1;
        chk({tag, "_exc"}, 32'(exc), 32'd1);
        chk({tag, "_badaddr"}, badaddr, a);
        chk({tag, "_ce"}, 32'(ce), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        step();
        chk({tag, "_exc_end"}, 32'(exc), 32'd0);
        chk({tag, "_ce_end"}, 32'(ce), 32'd0);
        chk({tag, "_done_end"}, 32'(done), 32'd0);
        chk({tag, "_rdata"}, rdata, erdata);
    endtask

    // LW latency and back-to-back acceptance on the WAIT_STATES=0/15 instances.
    task automatic lat_test(input string tag, input int w, input int exp_lat,
                            input logic [31:0] exp_rd);
        int n;
        logic d;
        for (int k = 0; k < 2; k++) begin
            op = 3'b100; addr = 32'h40;
            if (w == 0) req0 = 1'b1; else req15 = 1'b1;
            #1;
            chk({tag, "_accept_stall"}, 32'((w == 0) ? stall0 : stall15), 32'd1);
            @(posedge clk);
            #1 req0 = 1'b0; req15 = 1'b0;
            #1;
            chk({tag, "_ce"}, 32'((w == 0) ? ce0 : ce15), 32'd1);
            n = 1;
            d = (w == 0) ? done0 : done15;
            while (!d && n < 40) begin
                step();
                n++;
                d = (w == 0) ? done0 : done15;
            end
            chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
            chk({tag, "_rdata"}, (w == 0) ? rdata0 : rdata15, exp_rd);
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        rst = 1'b0; req = 1'b0; req0 = 1'b0; req15 = 1'b0;
        op = 3'b000; addr = 32'h0; wdata = 32'h0; flush = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_ce_we_done_exc_stall", 32'({ce, we, done, exc, stall}), 32'd0);
        chk("rst_addr", maddr, 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_data", mdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_badaddr", badaddr, 32'h0);
        step();
        step();
        rst = 1'b0;
        step();

        do_access("sw",   3'b111, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0);
        do_access("lw",   3'b100, 32'h100, 32'h0,        4'b1111, 32'h0,        1'b0, 32'hDEADBEEF);
        do_access("sb1",  3'b101, 32'h101, 32'h00000055, 4'b0100, 32'h55555555, 1'b1, 32'hDEADBEEF);
        do_access("lb1",  3'b000, 32'h101, 32'h0,        4'b0100, 32'h0,        1'b0, 32'h00000055);
        do_access("sb2",  3'b101, 32'h102, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 1'b1, 32'h00000055);
        do_access("lb2",  3'b000, 32'h102, 32'h0,        4'b0010, 32'h0,        1'b0, 32'hFFFFFFA5);
        do_access("lbu2", 3'b001, 32'h102, 32'h0,        4'b0010, 32'h0,        1'b0, 32'h000000A5);
        do_access("sh",   3'b110, 32'h202, 32'h00008001, 4'b0011, 32'h80018001, 1'b1, 32'h000000A5);
        do_access("lh",   3'b010, 32'h202, 32'h0,        4'b0011, 32'h0,        1'b0, 32'hFFFF8001);
        do_access("lhu",  3'b011, 32'h202, 32'h0,        4'b0011, 32'h0,        1'b0, 32'h00008001);
        do_access("lb0",  3'b000, 32'h100, 32'h0,        4'b1000, 32'h0,        1'b0, 32'hFFFFFFDE);
        chk("ram_word_100", ram[32'h100 >> 2], 32'hDE55A5EF);

        do_err("lw_mis", 3'b100, 32'h203, 32'hFFFFFFDE);
        do_err("sh_mis", 3'b110, 32'h201, 32'hFFFFFFDE);
        do_err("sw_mis", 3'b111, 32'h102, 32'hFFFFFFDE);

        // Flush in IDLE suppresses the stall and the accept.
        op = 3'b100; addr = 32'h100; req = 1'b1; flush = 1'b1;
        #1;
        chk("flush_idle_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 req = 1'b0; flush = 1'b0;
        #1;
        chk("flush_idle_ce", 32'(ce), 32'd0);

        // Flush during ACCESS of an LW.
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        #1;
        chk("flush_acc_ce", 32'(ce), 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_acc_stall", 32'(stall), 32'd1);
        step();
        flush = 1'b0;
        #1;
        chk("flush_after_ce", 32'(ce), 32'd0);
        chk("flush_after_done", 32'(done), 32'd0);
        chk("flush_after_stall", 32'(stall), 32'd0);
        step();
        chk("flush_no_done", 32'({done, exc}), 32'd0);
        chk("flush_rdata", rdata, 32'hFFFFFFDE);

        // Reset mid-ACCESS of an SW.
        op = 3'b111; addr = 32'h300; wdata = 32'h11223344; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        #1;
        chk("rstmid_ce", 32'({ce, we}), 32'd3);
        rst = 1'b1;
        #1;
        chk("rstmid_ctl", 32'({ce, we, done, exc, stall}), 32'd0);
        chk("rstmid_addr", maddr, 32'h0);
        chk("rstmid_sel", 32'(sel), 32'h0);
        chk("rstmid_data", mdata, 32'h0);
        chk("rstmid_rdata", rdata, 32'h0);
        chk("rstmid_ram", ram[32'h300 >> 2], 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("rstmid_idle", 32'({ce, done, exc}), 32'd0);

        lat_test("w0",  0,  2, 32'h12345678);
        lat_test("w15", 15, 17, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
